// File: rtl/pipeline_controller_pkg.sv
// pipeline_controller_pkg
// Shared encodings and widths for the pipeline controller and its
// forwarding-select sub-module.
//   pc_src_e   : next-PC source select (PC+1 / const / offset / stack)
//   fwd_sel_e  : EX operand source select (RF / MEM ALU result / WB data)
//   state_e    : controller state (RUN / DRAIN / HALTED)
//   REG_ID_W   : register-id width
//   CNT_W      : performance counter width
package pipeline_controller_pkg;

  localparam int REG_ID_W = 3;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'd0,
    PC_SRC_CONST  = 2'd1,
    PC_SRC_OFFSET = 2'd2,
    PC_SRC_STACK  = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_controller_fwd_select.sv
// fwd_select
// Chooses the source of one EX operand. A pending MEM-stage write to the
// same register wins over a WB-stage write because it is the younger value.
// Register 0 is treated like any other register.
// Ports:
//   ex_rs   in  EX operand register id
//   mem_rd  in  MEM destination id,  mem_we in MEM write enable
//   wb_rd   in  WB destination id,   wb_we  in WB write enable
//   sel     out forwarding select (fwd_sel_e encoding)
module fwd_select
  import pipeline_controller_pkg::*;
(
  input  logic [REG_ID_W-1:0] ex_rs,
  input  logic [REG_ID_W-1:0] mem_rd,
  input  logic                mem_we,
  input  logic [REG_ID_W-1:0] wb_rd,
  input  logic                wb_we,
  output logic [1:0]          sel
);

  // Operand source priority: MEM, then WB, then register file.
  always_comb begin
    sel = FWD_RF;
    if (mem_we && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller
// Hazard, redirect, forwarding and halt control for a 5-stage pipeline.
// Ports:
//   clk, rst (sync active-low)
//   id_*            ID-stage decode info (sources, branch/jump/ret)
//   ex_*            EX-stage info (dest, load, flag-writer, operand ids)
//   mem_*, wb_*     MEM/WB destination ids and write enables
//   halt_req        level request to drain and freeze the pipeline
//   clr_cnt         clears the performance counters
//   pc_ld, pr1_ld, pr1_flush, pr2_flush, pc_src, stack_en : pipeline control
//   fwd_a_sel, fwd_b_sel : EX operand forwarding selects
//   halt_ack        registered, high while HALTED
//   stall_cnt, flush_cnt : saturating performance counters
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_ID_W-1:0] id_rs1,
  input  logic [REG_ID_W-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                id_cond_branch,
  input  logic                id_branch_taken,
  input  logic                id_jump_const,
  input  logic                id_ret,
  input  logic [REG_ID_W-1:0] ex_rd,
  input  logic                ex_mem_read,
  input  logic                ex_sets_flags,
  input  logic [REG_ID_W-1:0] ex_rs1,
  input  logic [REG_ID_W-1:0] ex_rs2,
  input  logic [REG_ID_W-1:0] mem_rd,
  input  logic [REG_ID_W-1:0] wb_rd,
  input  logic                mem_we,
  input  logic                wb_we,
  input  logic                halt_req,
  input  logic                clr_cnt,
  output logic                pc_ld,
  output logic                pr1_ld,
  output logic                pr1_flush,
  output logic                pr2_flush,
  output logic [1:0]          pc_src,
  output logic                stack_en,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                halt_ack,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  // Drain counter needs at least one bit even for DRAIN_CYCLES == 1.
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               halt_ack_q, halt_ack_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic               load_use_s;
  logic               flag_haz_s;
  logic               run_s;
  logic               stall_s;
  logic               redirect_s;
  pc_src_e            pc_src_s;
  logic [1:0]         fwd_a_raw_s;
  logic [1:0]         fwd_b_raw_s;

  fwd_select u_fwd_a (
    .ex_rs  (ex_rs1),
    .mem_rd (mem_rd),
    .mem_we (mem_we),
    .wb_rd  (wb_rd),
    .wb_we  (wb_we),
    .sel    (fwd_a_raw_s)
  );

  fwd_select u_fwd_b (
    .ex_rs  (ex_rs2),
    .mem_rd (mem_rd),
    .mem_we (mem_we),
    .wb_rd  (wb_rd),
    .wb_we  (wb_we),
    .sel    (fwd_b_raw_s)
  );

  // Hazard and redirect qualification; only meaningful in RUN.
  always_comb begin
    load_use_s = ex_mem_read &&
                 (((ex_rd == id_rs1) && id_use_rs1) ||
                  ((ex_rd == id_rs2) && id_use_rs2));
    flag_haz_s = id_cond_branch && ex_sets_flags;
    run_s      = (state_q == ST_RUN);
    stall_s    = run_s && (load_use_s || flag_haz_s);
    redirect_s = run_s && !stall_s && (id_ret || id_jump_const || id_branch_taken);
  end

  // Control outputs and next-state; defaults are the frozen/bubble values.
  always_comb begin
    pc_ld       = 1'b0;
    pr1_ld      = 1'b0;
    pr1_flush   = 1'b1;
    pr2_flush   = 1'b1;
    stack_en    = 1'b0;
    pc_src_s    = PC_SRC_SEQ;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (!rst) begin
      state_d     = ST_RUN;
      drain_cnt_d = DRAIN_W'(0);
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stall_s) begin
            pr1_ld    = 1'b0;
            pr1_flush = 1'b0;
            pr2_flush = 1'b1;
          end else if (redirect_s) begin
            pc_ld     = 1'b1;
            pr1_ld    = 1'b1;
            pr1_flush = 1'b1;
            pr2_flush = 1'b0;
            stack_en  = 1'b1;
            if (id_ret) begin
              pc_src_s = PC_SRC_STACK;
            end else if (id_jump_const) begin
              pc_src_s = PC_SRC_CONST;
            end else begin
              pc_src_s = PC_SRC_OFFSET;
            end
          end else begin
            pc_ld     = 1'b1;
            pr1_ld    = 1'b1;
            pr1_flush = 1'b0;
            pr2_flush = 1'b0;
            stack_en  = 1'b1;
            if (halt_req) begin
              state_d     = ST_DRAIN;
              drain_cnt_d = DRAIN_W'(DRAIN_CYCLES - 1);
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == DRAIN_W'(0)) begin
            state_d = ST_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
          end
        end
        ST_HALTED: begin
          if (!halt_req) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HALTED;
          end
        end
        default: begin
          state_d     = ST_RUN;
          drain_cnt_d = DRAIN_W'(0);
        end
      endcase
    end
  end

  // halt_ack follows the HALTED state one edge later, like the state itself.
  always_comb begin
    halt_ack_d = (state_d == ST_HALTED);
  end

  // Saturating counters; clear wins over an increment in the same cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = CNT_W'(0);
      flush_cnt_d = CNT_W'(0);
    end else begin
      if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (redirect_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State, drain counter, halt_ack and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= DRAIN_W'(0);
      halt_ack_q  <= 1'b0;
      stall_cnt_q <= CNT_W'(0);
      flush_cnt_q <= CNT_W'(0);
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halt_ack_q  <= halt_ack_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Forwarding selects are held at RF while in reset.
  always_comb begin
    if (!rst) begin
      fwd_a_sel = 2'd0;
      fwd_b_sel = 2'd0;
    end else begin
      fwd_a_sel = fwd_a_raw_s;
      fwd_b_sel = fwd_b_raw_s;
    end
  end

  assign pc_src    = pc_src_s;
  assign halt_ack  = halt_ack_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller
// Directed bench for pipeline_controller with hand-computed expectations.
module tb_pipeline_controller;

  logic       clk;
  logic       rst;
  logic [2:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, id_cond_branch, id_branch_taken;
  logic       id_jump_const, id_ret, ex_mem_read, ex_sets_flags;
  logic       mem_we, wb_we, halt_req, clr_cnt;
  logic       pc_ld, pr1_ld, pr1_flush, pr2_flush, stack_en, halt_ack;
  logic [1:0] pc_src, fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks;
  int n_fail;

  pipeline_controller #(.DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_cond_branch(id_cond_branch), .id_branch_taken(id_branch_taken),
    .id_jump_const(id_jump_const), .id_ret(id_ret),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_sets_flags(ex_sets_flags),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_we(mem_we), .wb_we(wb_we),
    .halt_req(halt_req), .clr_cnt(clr_cnt),
    .pc_ld(pc_ld), .pr1_ld(pr1_ld), .pr1_flush(pr1_flush), .pr2_flush(pr2_flush),
    .pc_src(pc_src), .stack_en(stack_en),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .halt_ack(halt_ack), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 3'd0; id_rs2 = 3'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_cond_branch = 1'b0; id_branch_taken = 1'b0; id_jump_const = 1'b0; id_ret = 1'b0;
    ex_rd = 3'd0; ex_mem_read = 1'b0; ex_sets_flags = 1'b0; ex_rs1 = 3'd0; ex_rs2 = 3'd0;
    mem_rd = 3'd0; wb_rd = 3'd0; mem_we = 1'b0; wb_we = 1'b0;
    halt_req = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs1 = 3'd3; id_use_rs1 = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_in();
    rst = 1'b0;
    // forwarding match present during reset must still read RF
    ex_rs1 = 3'd2; mem_rd = 3'd2; mem_we = 1'b1;
    tick();
    tick();
    check("rst_pc_ld", {31'd0, pc_ld}, 32'd0);
    check("rst_pr1_ld", {31'd0, pr1_ld}, 32'd0);
    check("rst_pr1_flush", {31'd0, pr1_flush}, 32'd1);
    check("rst_pr2_flush", {31'd0, pr2_flush}, 32'd1);
    check("rst_stack_en", {31'd0, stack_en}, 32'd0);
    check("rst_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    check("rst_halt_ack", {31'd0, halt_ack}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);

    // normal RUN
    clear_in();
    rst = 1'b1;
    tick();
    check("run_pc_ld", {31'd0, pc_ld}, 32'd1);
    check("run_pr1_ld", {31'd0, pr1_ld}, 32'd1);
    check("run_pr1_flush", {31'd0, pr1_flush}, 32'd0);
    check("run_pr2_flush", {31'd0, pr2_flush}, 32'd0);
    check("run_pc_src", {30'd0, pc_src}, 32'd0);
    check("run_stack_en", {31'd0, stack_en}, 32'd1);

    // load-use: source not actually read -> no stall
    set_load_use();
    id_use_rs1 = 1'b0;
    #1;
    check("lu_unused_pc_ld", {31'd0, pc_ld}, 32'd1);
    // load with matching rs2 that is read -> stall
    id_rs2 = 3'd3; id_use_rs2 = 1'b1;
    #1;
    check("lu_rs2_pc_ld", {31'd0, pc_ld}, 32'd0);
    // non-load with matching source -> no stall
    ex_mem_read = 1'b0;
    #1;
    check("lu_noload_pc_ld", {31'd0, pc_ld}, 32'd1);
    clear_in();
    set_load_use();
    #1;
    check("lu_pc_ld", {31'd0, pc_ld}, 32'd0);
    check("lu_pr1_ld", {31'd0, pr1_ld}, 32'd0);
    check("lu_pr2_flush", {31'd0, pr2_flush}, 32'd1);
    check("lu_stack_en", {31'd0, stack_en}, 32'd0);
    tick();
    check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    clear_in();

    // flag hazard with taken branch: stall, no redirect
    id_cond_branch = 1'b1; ex_sets_flags = 1'b1; id_branch_taken = 1'b1;
    #1;
    check("flag_pc_ld", {31'd0, pc_ld}, 32'd0);
    check("flag_pc_src", {30'd0, pc_src}, 32'd0);
    check("flag_pr1_flush", {31'd0, pr1_flush}, 32'd0);
    check("flag_pr2_flush", {31'd0, pr2_flush}, 32'd1);
    tick();
    check("flag_stall_cnt", {16'd0, stall_cnt}, 32'd2);
    check("flag_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    ex_sets_flags = 1'b0;
    #1;
    check("br_pc_src", {30'd0, pc_src}, 32'd2);
    check("br_pr1_flush", {31'd0, pr1_flush}, 32'd1);
    check("br_pc_ld", {31'd0, pc_ld}, 32'd1);
    tick();
    check("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    clear_in();

    // redirect priority
    id_ret = 1'b1; id_jump_const = 1'b1; id_branch_taken = 1'b1;
    #1;
    check("prio_ret", {30'd0, pc_src}, 32'd3);
    id_ret = 1'b0;
    #1;
    check("prio_jump", {30'd0, pc_src}, 32'd1);
    tick();
    check("prio_flush_cnt", {16'd0, flush_cnt}, 32'd2);
    clear_in();

    // forwarding
    ex_rs2 = 3'd5; mem_rd = 3'd5; wb_rd = 3'd5; mem_we = 1'b1; wb_we = 1'b1;
    #1;
    check("fwd_b_mem", {30'd0, fwd_b_sel}, 32'd1);
    mem_we = 1'b0;
    #1;
    check("fwd_b_wb", {30'd0, fwd_b_sel}, 32'd2);
    wb_we = 1'b0;
    #1;
    check("fwd_b_rf", {30'd0, fwd_b_sel}, 32'd0);
    ex_rs1 = 3'd0; wb_rd = 3'd0; wb_we = 1'b1; mem_rd = 3'd4; mem_we = 1'b1;
    #1;
    check("fwd_a_r0_wb", {30'd0, fwd_a_sel}, 32'd2);
    check("fwd_b_indep", {30'd0, fwd_b_sel}, 32'd0);
    clear_in();

    // halt_req during a redirect is not honored
    halt_req = 1'b1; id_jump_const = 1'b1;
    tick();
    halt_req = 1'b0; id_jump_const = 1'b0;
    #1;
    check("halt_ignored_redir", {31'd0, pc_ld}, 32'd1);

    // halt on a clean cycle: 4 DRAIN cycles then halt_ack
    halt_req = 1'b1;
    #1;
    check("halt_clean_pc_ld", {31'd0, pc_ld}, 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_pc_ld", i), {31'd0, pc_ld}, 32'd0);
      check($sformatf("drain%0d_flush", i), {30'd0, pr1_flush, pr2_flush}, 32'd3);
      check($sformatf("drain%0d_ack", i), {31'd0, halt_ack}, 32'd0);
      tick();
    end
    check("halted_ack", {31'd0, halt_ack}, 32'd1);
    check("halted_pc_ld", {31'd0, pc_ld}, 32'd0);
    // a hazard while HALTED neither stalls-counts nor changes outputs
    set_load_use();
    tick();
    check("halted_no_count", {16'd0, stall_cnt}, 32'd2);
    check("halted_hold_ack", {31'd0, halt_ack}, 32'd1);
    clear_in();
    tick();
    check("resume_ack", {31'd0, halt_ack}, 32'd0);
    check("resume_pc_ld", {31'd0, pc_ld}, 32'd1);

    // halt_req dropped during DRAIN does not abort the drain
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort%0d_pc_ld", i), {31'd0, pc_ld}, 32'd0);
      tick();
    end
    check("abort_halted_ack", {31'd0, halt_ack}, 32'd1);
    tick();
    check("abort_resume_ack", {31'd0, halt_ack}, 32'd0);

    // reset mid-DRAIN
    halt_req = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rstdrain_flush", {30'd0, pr1_flush, pr2_flush}, 32'd3);
    check("rstdrain_pc_ld", {31'd0, pc_ld}, 32'd0);
    tick();
    check("rstdrain_ack", {31'd0, halt_ack}, 32'd0);
    check("rstdrain_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rstdrain_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    halt_req = 1'b0;
    rst = 1'b1;
    tick();
    check("rstdrain_run", {31'd0, pc_ld}, 32'd1);
    tick();
    check("rstdrain_no_ack", {31'd0, halt_ack}, 32'd0);

    // counter saturation and clear precedence
    set_load_use();
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
    end
    #1;
    check("sat_reach", {16'd0, stall_cnt}, 32'h0000_FFFF);
    tick();
    check("sat_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
    clr_cnt = 1'b1;
    tick();
    check("clr_wins", {16'd0, stall_cnt}, 32'd0);
    clear_in();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter DRAIN_CYCLES, default 4, sets the number of cycles the pipeline is emptied before halt_ack.
REQ-002 Ports, in order:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- id_rs1, id_rs2  in  3  ID source register ids.
- id_use_rs1, id_use_rs2  in  1  ID actually reads that source.
- id_cond_branch  in  1  ID holds a conditional branch (reads C/Z).
- id_branch_taken  in  1  ID offset branch resolved as taken.
- id_jump_const  in  1  ID holds an absolute jump or call.
- id_ret  in  1  ID holds a return.
- ex_rd  in  3  EX destination register id.
- ex_mem_read  in  1  EX instruction is a load.
- ex_sets_flags  in  1  EX instruction updates C/Z.
- ex_rs1, ex_rs2  in  3  EX operand register ids.
- mem_rd, wb_rd  in  3  MEM and WB destination register ids.
- mem_we, wb_we  in  1  MEM and WB register-file write enables.
- halt_req  in  1  external drain request (level).
- clr_cnt  in  1  clears the performance counters.
- pc_ld, pr1_ld  out  1  PC and IF/ID load enables.
- pr1_flush, pr2_flush  out  1  bubble into IF/ID or ID/EX.
- pc_src  out  2  0 = PC+1, 1 = const, 2 = offset, 3 = stack.
- stack_en  out  1  gates the ID push/pop.
- fwd_a_sel, fwd_b_sel  out  2  0 = RF, 1 = MEM ALU result, 2 = WB data.
- halt_ack  out  1  pipeline empty and frozen.
- stall_cnt, flush_cnt  out  16  performance counters.

Function
REQ-003 States: RUN, DRAIN, HALTED. The state is registered; all other control outputs except the counters and halt_ack are combinational from the state and the inputs.
REQ-004 A load-use hazard exists when ex_mem_read=1 and ex_rd equals id_rs1 with id_use_rs1=1, or ex_rd equals id_rs2 with id_use_rs2=1.
REQ-005 A flag hazard exists when id_cond_branch=1 and ex_sets_flags=1.
REQ-006 Stall (RUN with either hazard), for exactly that cycle:
- pc_ld=0, pr1_ld=0, pr2_flush=1, stack_en=0, pc_src=0.
- Re-evaluated each cycle; no state change.
REQ-007 Redirect applies in RUN with no stall:
- Priority id_ret > id_jump_const > id_branch_taken.
- pc_src=3, 1 or 2 respectively; pr1_flush=1, pc_ld=1, stack_en=1.
REQ-008 Normal RUN (no stall, no redirect): pc_ld=1, pr1_ld=1, both flushes 0, pc_src=0, stack_en=1.
REQ-009 halt_req is honored only on a RUN cycle that is neither a stall nor a redirect; that cycle behaves as normal RUN and moves to DRAIN next cycle.
REQ-010 DRAIN:
- pc_ld=0, pr1_flush=1, pr2_flush=1, stack_en=0.
- A down-counter loaded with DRAIN_CYCLES-1 is decremented each cycle; at 0 the block moves to HALTED.
- halt_req deasserting during DRAIN does not abort the drain.
REQ-011 HALTED:
- halt_ack=1 (registered); outputs as in DRAIN.
- When halt_req=0: next cycle is RUN with halt_ack=0.
REQ-012 Forwarding, each EX operand independently:
- Select 1 if mem_we=1 and mem_rd matches.
- Else select 2 if wb_we=1 and wb_rd matches.
- Else select 0.
- MEM beats WB when both match. No register id is special.
REQ-013 stall_cnt increments on every stall cycle; flush_cnt increments on every redirect cycle.
REQ-014 Both counters saturate at 0xFFFF and do not count in DRAIN or HALTED.
REQ-015 clr_cnt=1 zeroes both counters on that edge and takes precedence over an increment in the same cycle.

Reset
REQ-016 While rst=0, on each clock edge:
- State becomes RUN, drain counter 0, halt_ack 0, stall_cnt and flush_cnt 0.
REQ-017 While rst=0, combinational outputs are forced to pc_ld=0, pr1_ld=0, pr1_flush=1, pr2_flush=1, stack_en=0, pc_src=0, fwd selects 0.
REQ-018 Reset asserted mid-DRAIN or in HALTED returns the block to RUN on the next edge with no halt_ack pulse.

Structure
REQ-019 A shared package holds:
- the pc_src encoding enum.
- the fwd_sel encoding enum.
- the RUN/DRAIN/HALTED state enum.
- the register-id width constant (3) and counter width (16).
REQ-020 One sub-module, fwd_select, computes a single operand's forwarding select; it is instantiated twice, for operands A and B.

Verification
REQ-021 Directed scenarios:
- Load-use: ex_mem_read=1, ex_rd=3, id_rs1=3, id_use_rs1=1 -> one cycle with pc_ld=0, pr2_flush=1, stall_cnt 0->1.
- Flag hazard plus taken branch: id_cond_branch=1, ex_sets_flags=1, id_branch_taken=1 -> stall first, no redirect; next cycle with ex_sets_flags=0 -> pc_src=2, pr1_flush=1.
- Priority and forwarding: id_ret=1 with id_jump_const=1 -> pc_src=3. mem_rd=wb_rd=ex_rs2=5, mem_we=wb_we=1 -> fwd_b_sel=1; with mem_we=0 -> 2.
- Halt: halt_req=1 on a clean cycle, DRAIN_CYCLES=4 -> 4 DRAIN cycles, then halt_ack=1; halt_req=0 -> RUN with halt_ack=0 next cycle.
- Counters: preload stall_cnt to 0xFFFF, one more stall -> stays 0xFFFF; clr_cnt together with a stall -> 0.
- Reset: rst=0 during DRAIN -> next edge RUN, counters 0, pr1_flush=pr2_flush=1 while rst=0.
